// File: rtl/csc_pkg.sv
// csc_pkg: complex type, column packer FSM states and zero constant shared with csc_stor
package csc_pkg;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_A1,
        ST_A0,
        ST_S
    } pack_state_t;

    localparam cplx_t CPLX_ZERO = '{re: 32'd0, im: 32'd0};

endpackage

// File: rtl/csc_col_pack.sv
// csc_col_pack: groups a row-ordered tridiagonal nonzero stream into per-column a1/a0/s beats; CSC_COL_PACK_CHK_EN enables in_last frame checking
module csc_col_pack
    import csc_pkg::*;
#(
    parameter int MAT_RANK = 256,
    localparam int CW = $clog2(MAT_RANK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   in_val_r,
    input  logic [31:0]   in_val_i,
    input  logic          in_vld,
    input  logic          in_last,
    output logic          in_rdy,
    output logic [31:0]   s_val_r,
    output logic [31:0]   s_val_i,
    output logic [31:0]   a0_val_r,
    output logic [31:0]   a0_val_i,
    output logic [31:0]   a1_val_r,
    output logic [31:0]   a1_val_i,
    output logic          val_vld,
    output logic [CW-1:0] col_idx,
    output logic          done,
    output logic          err
);

    pack_state_t   r_state, w_next;
    logic [CW-1:0] r_col, r_col_out;
    cplx_t         r_a1, r_a0, r_out_a1, r_out_a0, r_out_s;
    cplx_t         w_in;
    logic          r_vld, r_done;
    logic          w_acc, w_last_col, w_col_end;

    assign w_in       = {in_val_r, in_val_i};
    assign in_rdy     = (r_state != ST_IDLE);
    assign w_acc      = in_vld && in_rdy;
    assign w_last_col = (r_col == CW'(MAT_RANK - 1));
    assign w_col_end  = w_acc && ((r_state == ST_A0 && w_last_col) || r_state == ST_S);

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;

    // next state: column 0 enters at A0, the last column leaves from A0
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_A0;
            ST_A1:   if (in_vld) w_next = ST_A0;
            ST_A0:   if (in_vld) w_next = w_last_col ? ST_IDLE : ST_S;
            ST_S:    if (in_vld) w_next = ST_A1;
            default: w_next = ST_IDLE;
        endcase
    end

    // column counter and partial column registers; a1 is cleared so column 0 reports zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_col <= '0;
            r_a1  <= CPLX_ZERO;
            r_a0  <= CPLX_ZERO;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_col <= '0;
                r_a1  <= CPLX_ZERO;
            end else if (w_col_end && !w_last_col)
                r_col <= r_col + CW'(1);
            if (w_acc && r_state == ST_A1) r_a1 <= w_in;
            if (w_acc && r_state == ST_A0) r_a0 <= w_in;
        end

    // column beat: the entry completing the column bypasses its partial register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
            r_col_out <= '0;
            r_out_a1  <= CPLX_ZERO;
            r_out_a0  <= CPLX_ZERO;
            r_out_s   <= CPLX_ZERO;
        end else begin
            r_vld  <= w_col_end;
            r_done <= w_col_end && w_last_col;
            if (w_col_end) begin
                r_col_out <= r_col;
                r_out_a1  <= r_a1;
                r_out_a0  <= (r_state == ST_A0) ? w_in : r_a0;
                r_out_s   <= (r_state == ST_S) ? w_in : CPLX_ZERO;
            end
        end

    assign val_vld  = r_vld;
    assign done     = r_done;
    assign col_idx  = r_col_out;
    assign s_val_r  = r_out_s.re;
    assign s_val_i  = r_out_s.im;
    assign a0_val_r = r_out_a0.re;
    assign a0_val_i = r_out_a0.im;
    assign a1_val_r = r_out_a1.re;
    assign a1_val_i = r_out_a1.im;

`ifdef CSC_COL_PACK_CHK_EN
    logic w_final;
    logic r_err;
    assign w_final = (r_state == ST_A0) && w_last_col;

    // in_last must be set on exactly the final entry of the frame
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_acc && (in_last != w_final);

    assign err = r_err;
`else
    logic w_unused;
    assign w_unused = in_last;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_csc_col_pack.sv
// tb_csc_col_pack: directed checks of csc_col_pack at MAT_RANK=4 and MAT_RANK=2
module tb_csc_col_pack;
    import csc_pkg::*;

    typedef struct {
        int          col;
        logic [63:0] a1;
        logic [63:0] a0;
        logic [63:0] s;
        logic        done;
        int          cyc;
    } strobe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start4, start2, in_vld, in_last;
    logic [31:0] in_r, in_i;

    logic        rdy4, vld4, done4, err4;
    logic [31:0] sr4, si4, a0r4, a0i4, a1r4, a1i4;
    logic [1:0]  col4;
    logic        rdy2, vld2, done2, err2;
    logic [31:0] sr2, si2, a0r2, a0i2, a1r2, a1i2;
    logic [0:0]  col2;

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int acc [1:16];
    strobe_t sq4[$], sq2[$];
    int eq4[$], eq2[$];

    csc_col_pack #(.MAT_RANK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_val_r(in_r), .in_val_i(in_i),
        .in_vld(in_vld), .in_last(in_last), .in_rdy(rdy4),
        .s_val_r(sr4), .s_val_i(si4), .a0_val_r(a0r4), .a0_val_i(a0i4),
        .a1_val_r(a1r4), .a1_val_i(a1i4), .val_vld(vld4), .col_idx(col4),
        .done(done4), .err(err4));

    csc_col_pack #(.MAT_RANK(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_val_r(in_r), .in_val_i(in_i),
        .in_vld(in_vld), .in_last(in_last), .in_rdy(rdy2),
        .s_val_r(sr2), .s_val_i(si2), .a0_val_r(a0r2), .a0_val_i(a0i2),
        .a1_val_r(a1r2), .a1_val_i(a1i2), .val_vld(vld2), .col_idx(col2),
        .done(done2), .err(err2));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld4) sq4.push_back('{int'(col4), {a1r4, a1i4}, {a0r4, a0i4}, {sr4, si4}, done4, cyc});
        if (vld2) sq2.push_back('{int'(col2), {a1r2, a1i2}, {a0r2, a0i2}, {sr2, si2}, done2, cyc});
        if (err4) eq4.push_back(cyc);
        if (err2) eq2.push_back(cyc);
    end

    function automatic logic [63:0] ev(input int j, input int slot, input int n, input int off);
        int k;
        if ((slot == 0 && j == 0) || (slot == 2 && j == n - 1)) return 64'd0;
        k = 3 * j + slot;
        return {32'(k), (off == 0) ? 32'd0 : 32'(k + off)};
    endfunction

    task automatic send(input bit sel, input int n, input bit tog, input int last_at,
                        input int start_at, input int off, input int cnt);
        int stalls = 0;
        sq4.delete(); sq2.delete(); eq4.delete(); eq2.delete();
        @(negedge clk);
        if (sel) start2 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; start4 = 1'b0;
        for (int k = 1; k <= cnt; k++) begin
            in_vld  = 1'b1;
            in_r    = 32'(k);
            in_i    = (off == 0) ? 32'd0 : 32'(k + off);
            in_last = (k == last_at);
            if (k == start_at) begin
                if (sel) start2 = 1'b1; else start4 = 1'b1;
            end
            if (!(sel ? rdy2 : rdy4)) stalls++;
            acc[k] = cyc;
            @(negedge clk);
            start2 = 1'b0; start4 = 1'b0;
            if (tog) begin
                in_vld = 1'b0;
                @(negedge clk);
            end
        end
        in_vld = 1'b0; in_last = 1'b0;
        ncmp++;
        if (stalls !== 0) begin
            nfail++;
            $display("FAIL in_rdy during frame: %0d entries refused, want 0", stalls);
        end
        if (n < 0) $display("unused n");
    endtask

    task automatic check_frame(input string nm, input bit sel, input int n, input int off,
                               input bit gap, input bit chk_err);
        strobe_t q[$];
        int eq[$];
        repeat (4) @(negedge clk);
        if (sel) begin q = sq2; eq = eq2; end else begin q = sq4; eq = eq4; end
        ncmp++;
        if (q.size() !== n) begin
            nfail++;
            $display("FAIL %s strobe count: got %0d want %0d", nm, q.size(), n);
        end
        for (int j = 0; j < n && j < q.size(); j++) begin
            int li = (j == n - 1) ? 3 * n - 2 : 3 * j + 2;
            ncmp++;
            if (q[j].col !== j || q[j].a1 !== ev(j, 0, n, off) || q[j].a0 !== ev(j, 1, n, off)
                || q[j].s !== ev(j, 2, n, off) || q[j].done !== (j == n - 1)) begin
                nfail++;
                $display("FAIL %s col%0d: got col=%0d a1=%h a0=%h s=%h done=%b want col=%0d a1=%h a0=%h s=%h done=%b",
                         nm, j, q[j].col, q[j].a1, q[j].a0, q[j].s, q[j].done,
                         j, ev(j, 0, n, off), ev(j, 1, n, off), ev(j, 2, n, off), j == n - 1);
            end
            ncmp++;
            if (q[j].cyc !== acc[li] + 1) begin
                nfail++;
                $display("FAIL %s col%0d latency: strobe cycle %0d want %0d", nm, j, q[j].cyc, acc[li] + 1);
            end
            if (gap && j > 0) begin
                ncmp++;
                if (q[j].cyc - q[j-1].cyc <= 2) begin
                    nfail++;
                    $display("FAIL %s col%0d spacing: gap %0d want >2", nm, j, q[j].cyc - q[j-1].cyc);
                end
            end
        end
        ncmp++;
        if ((sel ? rdy2 : rdy4) !== 1'b0) begin
            nfail++;
            $display("FAIL %s in_rdy after done: got 1 want 0", nm);
        end
        if (chk_err) begin
            ncmp++;
            if (eq.size() !== 0) begin
                nfail++;
                $display("FAIL %s err pulses: got %0d want 0", nm, eq.size());
            end
        end
    endtask

    task automatic test_reset();
        ncmp++;
        if (rdy4 !== 1'b0 || vld4 !== 1'b0 || done4 !== 1'b0 || err4 !== 1'b0 || col4 !== 2'd0
            || {sr4, si4, a0r4, a0i4, a1r4, a1i4} !== 192'd0) begin
            nfail++;
            $display("FAIL reset dut4: rdy=%b vld=%b done=%b err=%b col=%0d a0r=%h want all 0",
                     rdy4, vld4, done4, err4, col4, a0r4);
        end
        ncmp++;
        if (rdy2 !== 1'b0 || vld2 !== 1'b0 || done2 !== 1'b0 || err2 !== 1'b0) begin
            nfail++;
            $display("FAIL reset dut2: rdy=%b vld=%b done=%b err=%b want 0", rdy2, vld2, done2, err2);
        end
    endtask

    task automatic test_basic();
        send(1'b0, 4, 1'b0, 10, 0, 0, 10);
        check_frame("basic", 1'b0, 4, 0, 1'b0, 1'b1);
    endtask

    task automatic test_toggle();
        send(1'b0, 4, 1'b1, 10, 0, 0, 10);
        check_frame("toggle", 1'b0, 4, 0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        send(1'b0, 4, 1'b0, 10, 0, 100, 10);
        check_frame("b2b_a", 1'b0, 4, 100, 1'b0, 1'b1);
        send(1'b0, 4, 1'b0, 10, 0, 200, 10);
        check_frame("b2b_b", 1'b0, 4, 200, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send(1'b0, 4, 1'b0, 0, 0, 0, 4);
        rst_n = 1'b0;
        #1;
        ncmp++;
        if (rdy4 !== 1'b0 || vld4 !== 1'b0 || col4 !== 2'd0 || {sr4, si4, a0r4, a0i4, a1r4, a1i4} !== 192'd0) begin
            nfail++;
            $display("FAIL reset_mid: rdy=%b vld=%b col=%0d a0r=%h sr=%h want 0", rdy4, vld4, col4, a0r4, sr4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 4, 1'b0, 10, 0, 0, 10);
        check_frame("after_reset", 1'b0, 4, 0, 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        send(1'b0, 4, 1'b0, 10, 5, 0, 10);
        check_frame("start_mid", 1'b0, 4, 0, 1'b0, 1'b1);
    endtask

    task automatic test_err();
        int want[$];
`ifdef CSC_COL_PACK_CHK_EN
        bit en = 1'b1;
`else
        bit en = 1'b0;
`endif
        send(1'b0, 4, 1'b0, 5, 0, 0, 10);
        check_frame("err_frame", 1'b0, 4, 0, 1'b0, 1'b0);
        if (en) want = '{acc[5] + 1, acc[10] + 1};
        ncmp++;
        if (eq4.size() !== want.size()) begin
            nfail++;
            $display("FAIL err count: got %0d want %0d", eq4.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < eq4.size(); i++) begin
            ncmp++;
            if (eq4[i] !== want[i]) begin
                nfail++;
                $display("FAIL err pulse %0d cycle: got %0d want %0d", i, eq4[i], want[i]);
            end
        end
    endtask

    task automatic test_rank2();
        send(1'b1, 2, 1'b0, 4, 0, 0, 4);
        check_frame("rank2", 1'b1, 2, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start4 = 1'b0; start2 = 1'b0;
        in_vld = 1'b0; in_last = 1'b0; in_r = '0; in_i = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        test_err();
        test_rank2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/csc_col_pack.md
# csc_col_pack

Upstream packer for `csc_stor`. It accepts a row-ordered stream of complex nonzeros of a tridiagonal `MAT_RANK`×`MAT_RANK` matrix, one column at a time. It groups each column's entries into the super-diagonal (`a1`), diagonal (`a0`) and sub-diagonal (`s`) slots. For every column it drives one `val_vld` beat carrying all three complex values and the column index.

## Interface
- `MAT_RANK`, default 256: matrix order N, with N ≥ 2.
- `CW`, default `$clog2(MAT_RANK)`: column index width (local parameter).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that arms the packer for one matrix.
- `in_val_r` in 32: real part of the input entry.
- `in_val_i` in 32: imaginary part of the input entry.
- `in_vld` in 1: input entry valid.
- `in_last` in 1: marks the final entry of the matrix.
- `in_rdy` out 1: packer accepts an entry this cycle.
- `s_val_r`, `s_val_i` out 32 each: sub-diagonal entry (row j+1).
- `a0_val_r`, `a0_val_i` out 32 each: diagonal entry (row j).
- `a1_val_r`, `a1_val_i` out 32 each: super-diagonal entry (row j-1).
- `val_vld` out 1: one-cycle strobe; the column outputs are valid.
- `col_idx` out CW: column j of the current strobe.
- `done` out 1: one-cycle pulse with the strobe of the last column.
- `err` out 1: frame error pulse (see Configuration).

## Operation
- Input order per column j is ascending row: `a1` (if j>0), then `a0`, then `s` (if j<N-1).
  - Column 0 carries 2 entries (`a0`, `s`).
  - Column N-1 carries 2 entries (`a1`, `a0`).
  - Every other column carries 3 entries.
  - A frame is 3N-2 entries in total.
- An entry is accepted when `in_vld && in_rdy`.
- FSM states:
  - IDLE: `in_rdy`=0. On `start`, clear the column counter to 0 and go to A0.
  - A1: accept into the `a1` register, then go to A0.
  - A0: accept into `a0`. If j=N-1, the column is complete; otherwise go to S.
  - S: accept into `s`; the column is complete.
  - On column complete:
    - If j=N-1, return to IDLE.
    - Otherwise increment j and go to A1.
- Slots that do not exist for a column are driven as 0: `a1` of column 0 and `s` of column N-1.
- `start` outside IDLE is ignored.
- `in_rdy` is 1 in A1, A0 and S, and 0 in IDLE. There is no downstream backpressure, because `csc_stor` always accepts.
- Output value registers and `col_idx` update only with `val_vld`. They hold their contents between strobes.

## Timing
- Reset values: `in_rdy`, `val_vld`, `done` and `err` are 0. All value outputs and `col_idx` are 0. FSM is in IDLE with j=0.
- `start` sampled high in cycle t puts `in_rdy`=1 from cycle t+1.
- If the last entry of column j is accepted in cycle t:
  - `val_vld`=1 and `col_idx`=j during cycle t+1, for exactly one cycle.
  - The next column's first entry may be accepted in cycle t+1, because the states are back-to-back.
  - Sustained throughput is one entry per cycle.
- `done` is coincident with the `val_vld` for column N-1. `in_rdy` is 0 from cycle t+1.
- A reset mid-frame discards partial column data. No strobe is issued. The FSM returns to IDLE.
- Stalls (`in_vld`=0) leave the state and partial registers unchanged for any number of cycles.

## Configuration
- `CSC_COL_PACK_CHK_EN` defined:
  - `err` pulses one cycle after an entry is accepted with `in_last`=1 anywhere other than the final entry (column N-1, A0 state).
  - `err` also pulses one cycle after the final entry is accepted with `in_last`=0.
  - Packing behaviour is unaffected by `err`.
- `CSC_COL_PACK_CHK_EN` undefined: `in_last` is ignored and `err` is tied to 0.

## Structure
- A shared package `csc_pkg` holds:
  - the complex type `cplx_t` (`{re, im}`, 32 bits each);
  - the FSM state enum;
  - the `CPLX_ZERO` constant.
- The package is shared with `csc_stor`.
- No sub-module; the FSM, counter and output registers live in one module.

## Test plan
- MAT_RANK=4, `start`, then 10 entries on consecutive cycles, values 1..10 real and 0 imaginary. Expect 4 strobes at `col_idx` 0..3:
  - column 0: `a1`=0, `a0`=1, `s`=2;
  - column 1: 3/4/5;
  - column 2: 6/7/8;
  - column 3: 9/10/`s`=0.
  - `done` is high with the column 3 strobe.
- Same frame with `in_vld` toggling every other cycle: identical strobes and values, and never two strobes within 2 cycles of each other.
- `rst_n` asserted after entry 4 of a MAT_RANK=4 frame: outputs are 0 immediately and `in_rdy`=0. A new `start` plus a full frame then gives 4 correct strobes.
- `start` pulsed mid-frame: ignored, and the frame completes normally with 4 strobes.
- With `CSC_COL_PACK_CHK_EN`:
  - `in_last` on entry 5: `err`=1 one cycle later and packing continues.
  - `in_last` absent on entry 10: `err`=1 one cycle after entry 10.
  - Without the macro: `err` stays 0 throughout.
- MAT_RANK=2: 4 entries 1..4 give column 0 (0/1/2) and column 1 (3/4/0), with `done` on the second strobe.
